zigzag_block_reader: RTL

Consumer end of the 8x8 (u,v) block-index stream. Accepts 64 coefficients, each tagged with its (u,v) position, into an 8x8 register buffer (FILL). It then replays them in JPEG zigzag order over a valid/ready stream to the entropy-coding stage (DRAIN). Sits between the transform/quantise stage (whose (u,v) come from the double counter) and the run-length/Huffman coder.

---
 rtl/zigzag_block_reader_pkg.sv | 33 +++
 rtl/zigzag_block_reader.sv | 105 ++++++++++
 2 files changed

// File: rtl/zigzag_block_reader_pkg.sv
// Shared 8x8 block codec definitions: index types, block FSM states and the
// zigzag-to-raster address table (also used by the decoder's un-zigzag path).
package zigzag_block_reader_pkg;

  localparam int BLK_DIM  = 8;
  localparam int BLK_SIZE = 64;

  typedef logic [2:0] uv_t;       // column u or row v inside a block
  typedef logic [5:0] zz_idx_t;   // position along the zigzag scan
  typedef logic [5:0] lin_addr_t; // raster address 8*v+u

  typedef enum logic {
    FILL,
    DRAIN
  } state_e;

  // Entry i is the raster address of the i-th coefficient in JPEG zigzag order.
  localparam lin_addr_t ZZ_ADDR [BLK_SIZE] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  function automatic lin_addr_t lin_addr(input uv_t u, input uv_t v);
    return {v, u};
  endfunction

endpackage

// File: rtl/zigzag_block_reader.sv
// Collects one 8x8 block of (u,v)-tagged coefficients, then streams it out in
// zigzag order over valid/ready. Fill and drain alternate; no double buffering.
module zigzag_block_reader
  import zigzag_block_reader_pkg::*;
#(
  parameter int COEF_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_u,
  input  logic [2:0]        in_v,
  input  logic [COEF_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_data,
  output logic [5:0]        out_idx,
  output logic              out_last,
  output logic              done
);

  state_e            state_q, state_d;
  zz_idx_t           wr_cnt_q, wr_cnt_d;
  zz_idx_t           rd_idx_q, rd_idx_d;
  logic              done_q, done_d;
  logic              wr_en;
  logic [COEF_W-1:0] mem_q [BLK_SIZE];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      wr_cnt_q <= '0;
      rd_idx_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_idx_q <= rd_idx_d;
      done_q   <= done_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_idx_d  = rd_idx_q;
    done_d    = 1'b0;
    wr_en     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (restart) begin
      // Flush both counters but keep the buffer contents.
      state_d  = FILL;
      wr_cnt_d = '0;
      rd_idx_d = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          in_ready = 1'b1;
          if (in_valid) begin
            wr_en    = 1'b1;
            wr_cnt_d = wr_cnt_q + 6'd1;
            if (wr_cnt_q == 6'd63) state_d = DRAIN;
          end
        end
        DRAIN: begin
          out_valid = 1'b1;
          if (out_ready) begin
            if (rd_idx_q == 6'd63) begin
              state_d  = FILL;
              wr_cnt_d = '0;
              rd_idx_d = '0;
              done_d   = 1'b1;
            end else begin
              rd_idx_d = rd_idx_q + 6'd1;
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // NOTE: the coefficient buffer is cleared on rst because a block that is only
  // partially rewritten must read 0 in the untouched entries; restart keeps it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BLK_SIZE; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[lin_addr(in_u, in_v)] <= in_data;
    end
  end

  assign out_data = mem_q[ZZ_ADDR[rd_idx_q]];
  assign out_idx  = rd_idx_q;
  assign out_last = out_valid && (rd_idx_q == 6'd63);
  assign done     = done_q;

endmodule
